// File: rtl/freq_sweep_if.sv
// Control/status bundle between the register interface and the sweep sequencer.
// The master drives the sweep programming; the slave returns the generator drive and status.
interface freq_sweep_if #(
    parameter int FREQ_WIDTH  = 12,
    parameter int DWELL_WIDTH = 16
);
    logic                   start;
    logic                   abort;
    logic                   mode;
    logic [FREQ_WIDTH-1:0]  freq_start;
    logic [FREQ_WIDTH-1:0]  freq_stop;
    logic [FREQ_WIDTH-1:0]  freq_step;
    logic [DWELL_WIDTH-1:0] dwell;
    logic [FREQ_WIDTH-1:0]  freq;
    logic                   nco_resetn;
    logic                   busy;
    logic                   step_tick;
    logic                   done;

    modport master (
        output start, abort, mode, freq_start, freq_stop, freq_step, dwell,
        input  freq, nco_resetn, busy, step_tick, done
    );

    modport slave (
        input  start, abort, mode, freq_start, freq_stop, freq_step, dwell,
        output freq, nco_resetn, busy, step_tick, done
    );
endinterface

// File: rtl/freq_sweep_ctrl.sv
// Stepped frequency sweep sequencer feeding the CORDIC generator's freq word.
// Also gates the generator reset so its phase restarts at every new sweep.
//
//   state | meaning
//   IDLE  | waiting for start; freq parked at 0, generator held in reset
//   DWELL | holding freq for the programmed dwell, then stepping or wrapping
//   DONE  | one-cycle done pulse; freq holds last value, generator in reset
module freq_sweep_ctrl #(
    parameter int FREQ_WIDTH  = 12,
    parameter int DWELL_WIDTH = 16
) (
    input  logic           i_clock,
    input  logic           i_resetn,
    freq_sweep_if.slave    sw
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [FREQ_WIDTH-1:0]  r_freq, w_freq_nxt;
    logic [DWELL_WIDTH-1:0] r_cnt, w_cnt_nxt;
    logic                   r_nco_resetn, w_nco_resetn_nxt;
    logic                   r_busy, w_busy_nxt;
    logic                   r_step_tick, w_step_tick_nxt;
    logic                   r_done, w_done_nxt;

    logic [FREQ_WIDTH-1:0]  r_start_sh, r_stop_sh, r_step_sh;
    logic [DWELL_WIDTH-1:0] r_reload_sh;
    logic                   r_mode_sh;
    logic                   w_capture;

    logic [FREQ_WIDTH:0]    w_next;
    logic                   w_sweep_end;

    // One extra bit so a carry out of the frequency word reads as "past stop".
    assign w_next      = {1'b0, r_freq} + {1'b0, r_step_sh};
    assign w_sweep_end = (r_step_sh == '0) || (w_next > {1'b0, r_stop_sh});
    assign w_capture   = (r_state == IDLE) && sw.start;

    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state      <= IDLE;
            r_freq       <= '0;
            r_cnt        <= '0;
            r_nco_resetn <= 1'b0;
            r_busy       <= 1'b0;
            r_step_tick  <= 1'b0;
            r_done       <= 1'b0;
            r_start_sh   <= '0;
            r_stop_sh    <= '0;
            r_step_sh    <= '0;
            r_reload_sh  <= '0;
            r_mode_sh    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_freq       <= w_freq_nxt;
            r_cnt        <= w_cnt_nxt;
            r_nco_resetn <= w_nco_resetn_nxt;
            r_busy       <= w_busy_nxt;
            r_step_tick  <= w_step_tick_nxt;
            r_done       <= w_done_nxt;
            if (w_capture) begin
                r_start_sh  <= sw.freq_start;
                r_stop_sh   <= sw.freq_stop;
                r_step_sh   <= sw.freq_step;
                r_reload_sh <= (sw.dwell == '0) ? '0 : sw.dwell - DWELL_WIDTH'(1);
                r_mode_sh   <= sw.mode;
            end
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_freq_nxt       = r_freq;
        w_cnt_nxt        = r_cnt;
        w_nco_resetn_nxt = r_nco_resetn;
        w_busy_nxt       = r_busy;
        w_step_tick_nxt  = 1'b0;
        w_done_nxt       = 1'b0;

        unique case (r_state)
            IDLE: begin
                w_freq_nxt = '0;
                if (sw.start) begin
                    w_state_nxt      = DWELL;
                    w_freq_nxt       = sw.freq_start;
                    w_cnt_nxt        = (sw.dwell == '0) ? '0 : sw.dwell - DWELL_WIDTH'(1);
                    w_busy_nxt       = 1'b1;
                    w_nco_resetn_nxt = 1'b1;
                end
            end
            DWELL: begin
                if (sw.abort) begin
                    w_state_nxt      = DONE;
                    w_done_nxt       = 1'b1;
                    w_busy_nxt       = 1'b0;
                    w_nco_resetn_nxt = 1'b0;
                end else if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - DWELL_WIDTH'(1);
                end else if (!w_sweep_end) begin
                    w_freq_nxt      = w_next[FREQ_WIDTH-1:0];
                    w_cnt_nxt       = r_reload_sh;
                    w_step_tick_nxt = 1'b1;
                end else if (r_mode_sh) begin
                    // Continuous wrap keeps the generator out of reset for phase continuity.
                    w_freq_nxt      = r_start_sh;
                    w_cnt_nxt       = r_reload_sh;
                    w_step_tick_nxt = 1'b1;
                end else begin
                    w_state_nxt      = DONE;
                    w_done_nxt       = 1'b1;
                    w_busy_nxt       = 1'b0;
                    w_nco_resetn_nxt = 1'b0;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
                w_freq_nxt  = '0;
                w_cnt_nxt   = '0;
            end
            default: begin
                w_state_nxt      = IDLE;
                w_freq_nxt       = '0;
                w_cnt_nxt        = '0;
                w_busy_nxt       = 1'b0;
                w_nco_resetn_nxt = 1'b0;
            end
        endcase
    end

    assign sw.freq       = r_freq;
    assign sw.nco_resetn = r_nco_resetn;
    assign sw.busy       = r_busy;
    assign sw.step_tick  = r_step_tick;
    assign sw.done       = r_done;

endmodule
